// File: rtl/req_arbiter_pkg.sv
// Shared constants for the request arbiter: sizes, FSM encoding and a
// one-hot helper used when registering a grant.
package req_arbiter_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      id_to_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << id;
   endfunction

endpackage

// File: rtl/rot_prio_sel.sv
// Combinational winner search: fixed priority (7 down to 0) or round-robin
// starting just below last_id and ending on last_id itself.
module rot_prio_sel
   import req_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_id,
   input  logic             rr_en,
   output logic [ID_W-1:0]  win_id,
   output logic             any_valid
);

   logic [ID_W-1:0] base_s;
   logic [ID_W-1:0] idx_s;

   // Scan from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      base_s    = {ID_W{1'b0}};
      idx_s     = {ID_W{1'b0}};
      win_id    = {ID_W{1'b0}};
      any_valid = |req;
      if (rr_en) begin
         base_s = last_id;
      end else begin
         base_s = {ID_W{1'b0}};
      end
      for (int k = N_REQ; k >= 1; k--) begin
         idx_s = base_s - ID_W'(k);
         if (req[idx_s]) begin
            win_id = idx_s;
         end else begin
            win_id = win_id;
         end
      end
   end

endmodule

// File: rtl/req_arbiter.sv
// Two-state request arbiter with registered one-hot grant, bounded hold time
// and a preempt pulse when an owner is forced off by the timeout.
module req_arbiter
   import req_arbiter_pkg::*;
#(
   parameter int N_REQ    = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req,
   input  logic             rr_en,
   output logic [7:0]       gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

   logic [0:0]      state_q,     state_d;
   logic [7:0]      gnt_q,       gnt_d;
   logic [ID_W-1:0] gnt_id_q,    gnt_id_d;
   logic            gnt_valid_q, gnt_valid_d;
   logic            preempt_q,   preempt_d;
   logic [HC_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic [ID_W-1:0] last_id_q,   last_id_d;

   logic [ID_W-1:0] win_id_s;
   logic            any_valid_s;
   logic            owner_req_s;
   logic            timeout_s;

   rot_prio_sel u_sel (
      .req       (req),
      .last_id   (last_id_q),
      .rr_en     (rr_en),
      .win_id    (win_id_s),
      .any_valid (any_valid_s)
   );

   // Next-state and output computation for the IDLE/GRANT machine.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      preempt_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      last_id_d   = last_id_q;
      owner_req_s = req[gnt_id_q];
      timeout_s   = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
      case (state_q)
         IDLE: begin
            if (any_valid_s) begin
               state_d     = GRANT;
               gnt_d       = id_to_onehot(win_id_s);
               gnt_id_d    = win_id_s;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = {HC_W{1'b0}};
               last_id_d   = win_id_s;
            end else begin
               gnt_d       = 8'h00;
               gnt_id_d    = {ID_W{1'b0}};
               gnt_valid_d = 1'b0;
            end
         end
         GRANT: begin
            // Owner dropping on the timeout cycle counts as a normal release.
            if (!owner_req_s || timeout_s) begin
               state_d     = IDLE;
               gnt_d       = 8'h00;
               gnt_id_d    = {ID_W{1'b0}};
               gnt_valid_d = 1'b0;
               hold_cnt_d  = {HC_W{1'b0}};
               preempt_d   = owner_req_s & timeout_s;
            end else begin
               hold_cnt_d  = hold_cnt_q + HC_W'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = 8'h00;
            gnt_id_d    = {ID_W{1'b0}};
            gnt_valid_d = 1'b0;
            hold_cnt_d  = {HC_W{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= 8'h00;
         gnt_id_q    <= {ID_W{1'b0}};
         gnt_valid_q <= 1'b0;
         preempt_q   <= 1'b0;
         hold_cnt_q  <= {HC_W{1'b0}};
         last_id_q   <= {ID_W{1'b0}};
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         preempt_q   <= preempt_d;
         hold_cnt_q  <= hold_cnt_d;
         last_id_q   <= last_id_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Scoreboard bench for req_arbiter: a cycle-level behavioural model predicts
// the registered outputs, a monitor compares them on the falling edge.
module tb_req_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       rr_en;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] id;
      logic       valid;
      logic       preempt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: current owner (-1 = none), cycles it has been shown, last winner.
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = 0;
   bit m_pre   = 1'b0;

   req_arbiter #(.N_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .rr_en     (rr_en),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [7:0] r, input bit rr, input int last);
      int base;
      int idx;
      base = rr ? last : 0;
      for (int s = 1; s <= 8; s++) begin
         idx = ((base - s) % 8 + 8) % 8;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, queue the prediction after the edge.
   task automatic step(input bit r, input logic [7:0] rq, input bit rr);
      exp_t e;
      int   w;
      rst   = r;
      req   = rq;
      rr_en = rr;
      if (r) begin
         m_owner = -1; m_held = 0; m_last = 0; m_pre = 1'b0;
      end else if (m_owner < 0) begin
         m_pre = 1'b0;
         w = pick(rq, rr, m_last);
         if (w >= 0) begin
            m_owner = w; m_held = 1; m_last = w;
         end
      end else if (!rq[m_owner]) begin
         m_owner = -1; m_pre = 1'b0;
      end else if (m_held == MAX_HOLD) begin
         m_owner = -1; m_pre = 1'b1;
      end else begin
         m_held++; m_pre = 1'b0;
      end
      e.gnt     = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      e.id      = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      e.valid   = (m_owner >= 0);
      e.preempt = m_pre;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: compare every presented output cycle against the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gnt",       32'(gnt),       32'(e.gnt));
         check("gnt_id",    32'(gnt_id),    32'(e.id));
         check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
         check("preempt",   32'(preempt),   32'(e.preempt));
      end
   end

   initial begin
      logic [7:0] r;
      logic [7:0] keep;
      rst = 1'b1; req = 8'h00; rr_en = 1'b0;
      repeat (2) step(1'b1, 8'h00, 1'b0);
      repeat (2) step(1'b0, 8'h00, 1'b0);

      // Fixed priority: 0010_0110 -> id 5, held then timed out.
      repeat (7) step(1'b0, 8'h26, 1'b0);
      repeat (2) step(1'b0, 8'h00, 1'b0);

      // Round-robin from reset, each owner drops after two grant cycles.
      step(1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 30; i++) begin
         r = 8'hFF;
         if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
         step(1'b0, r, 1'b1);
      end

      // Timeout with constant request on id 0.
      step(1'b1, 8'h00, 1'b0);
      repeat (12) step(1'b0, 8'h01, 1'b0);

      // Owner drops exactly on the timeout cycle.
      step(1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) begin
         r = (m_owner == 0 && m_held == MAX_HOLD) ? 8'h00 : 8'h01;
         step(1'b0, r, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0);

      // Reset during grant of id 3, then 0x88 in round-robin must pick 7.
      repeat (2) step(1'b0, 8'h08, 1'b1);
      step(1'b1, 8'h08, 1'b1);
      repeat (2) step(1'b0, 8'h88, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // rr_en toggles during a grant of id 4; new mode used at the next arbitration.
      step(1'b0, 8'h10, 1'b1);
      step(1'b0, 8'h10, 1'b0);
      step(1'b0, 8'h10, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h22, 1'b1);
      repeat (2) step(1'b0, 8'h22, 1'b0);
      step(1'b0, 8'h00, 1'b0);

      // Random traffic with sticky requests so timeouts occur.
      keep = 8'h00;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) keep = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         step(($urandom_range(0, 63) == 0), keep, 1'($urandom));
      end

      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
